// File: rtl/fetch_unit_pkg.sv
// Shared instruction-set definitions for the fetch/decode front end.
// Defines the opcode map and the ALU operation codes used downstream.
package fetch_unit_pkg;

  typedef enum logic [7:0] {
    OP_ADD = 8'd0,
    OP_SUB = 8'd1,
    OP_AND = 8'd2,
    OP_OR  = 8'd3,
    OP_XOR = 8'd4,
    OP_SHL = 8'd5,
    OP_SHR = 8'd6,
    OP_INC = 8'd7,
    OP_DEC = 8'd8,
    OP_MOV = 8'd9,
    OP_LD  = 8'd10,
    OP_ST  = 8'd11,
    OP_NOP = 8'd12,
    OP_LDI = 8'd13,
    OP_JMP = 8'd14,
    OP_RST = 8'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SHL,
    ALU_SHR,
    ALU_PASS
  } alu_op_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register for the fetch unit.
// Next-value priority: reset vector > load > increment; pc_nxt_o exposes that value early.
module fetch_unit_pc_reg #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rst_vec_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] load_val_i,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_nxt_o
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (rst_vec_i) begin
      pc_d = RESET_VECTOR;
    end else if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o     = pc_q;
  assign pc_nxt_o = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetches opcode (+ immediate for LDI) over req/ack and
// hands {instr, imm} to decode with valid/ready; decode's jump/soft reset steer the PC.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                     ADDR_WIDTH   = 8,
  parameter int                     INSTR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [INSTR_WIDTH-1:0] OPC_LDI      = INSTR_WIDTH'(OP_LDI),
  parameter logic [INSTR_WIDTH-1:0] OPC_NOP      = INSTR_WIDTH'(OP_NOP)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [INSTR_WIDTH-1:0] imm,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   jmp_en,
  input  logic [ADDR_WIDTH-1:0]  jmp_target,
  input  logic                   soft_rst,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [15:0]            retired
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_IMM,
    S_ISSUE
  } state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [INSTR_WIDTH-1:0] imm_q, imm_d;
  logic                   req_q, req_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [15:0]            retired_q, retired_d;

  logic                   pc_inc, pc_load, pc_vec;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_nxt;

  fetch_unit_pc_reg #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_vec_i (pc_vec),
    .load_i    (pc_load),
    .load_val_i(jmp_target),
    .inc_i     (pc_inc),
    .pc_o      (pc_q),
    .pc_nxt_o  (pc_nxt)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    retired_d = retired_q;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    pc_vec    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // An ack seen before our first request after reset is stale and dropped.
        if (req_q && imem_ack) begin
          instr_d = imem_rdata;
          imm_d   = '0;
          pc_inc  = 1'b1;
          state_d = (imem_rdata == OPC_LDI) ? S_IMM : S_ISSUE;
        end
      end
      S_IMM: begin
        if (req_q && imem_ack) begin
          imm_d   = imem_rdata;
          pc_inc  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          retired_d = retired_q + 16'd1;
          pc_vec    = soft_rst;
          pc_load   = jmp_en;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // The request address always tracks the upcoming PC; it only moves when the PC does.
  assign req_d  = (state_d != S_ISSUE);
  assign addr_d = pc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instr_q   <= OPC_NOP;
      imm_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= RESET_VECTOR;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      retired_q <= retired_d;
    end
  end

  assign instr_valid = (state_q == S_ISSUE);
  assign instr       = instr_valid ? instr_q : OPC_NOP;
  assign imm         = instr_valid ? imm_q : '0;
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign pc          = pc_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: behavioural instruction memory with programmable wait
// states, plus scoreboards for issued instructions and fetch addresses.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [7:0]  imem_rdata = 8'h00;
  logic [7:0]  instr;
  logic [7:0]  imm;
  logic        instr_valid;
  logic        instr_ready;
  logic        jmp_en;
  logic [7:0]  jmp_target;
  logic        soft_rst;
  logic [7:0]  pc;
  logic [15:0] retired;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mem [256];
  int          ack_wait = 0;
  int          wcnt = 0;
  logic        stray_ack = 1'b0;
  logic [15:0] exp_q [$];
  logic [7:0]  exp_addr_q [$];
  logic [15:0] mon_e;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .imm        (imm),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jmp_en     (jmp_en),
    .jmp_target (jmp_target),
    .soft_rst   (soft_rst),
    .pc         (pc),
    .retired    (retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory responder: acks after ack_wait idle cycles of a held request.
  always @(negedge clk) begin
    if (imem_req) begin
      if (wcnt >= ack_wait) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        wcnt       = 0;
        if (exp_addr_q.size() > 0) check_eq("fetch_addr", imem_addr, exp_addr_q.pop_front());
      end else begin
        imem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      imem_ack   = stray_ack;
      imem_rdata = stray_ack ? 8'h0D : 8'h00;
      wcnt       = 0;
    end
  end

  // Issue monitor: every accepted instruction must match the scoreboard head.
  always @(negedge clk) begin
    if (instr_valid && instr_ready) begin
      check_eq("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check_eq("issue_instr", instr, mon_e[15:8]);
        check_eq("issue_imm", imm, mon_e[7:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    jmp_en      = 1'b0;
    soft_rst    = 1'b0;
    stray_ack   = 1'b0;
    ack_wait    = 0;
    tick();
    tick();
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 8'h01;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (!instr_valid && n < max) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, instr_valid, 1);
  endtask

  task automatic accept(input logic j, input logic [7:0] tgt, input logic s);
    instr_ready = 1'b1;
    jmp_en      = j;
    jmp_target  = tgt;
    soft_rst    = s;
    tick();
    instr_ready = 1'b0;
    jmp_en      = 1'b0;
    soft_rst    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cycles;
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    jmp_en      = 1'b0;
    jmp_target  = 8'h00;
    soft_rst    = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h01;
    tick();
    tick();
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_instr", instr, 12);
    check_eq("rst_imm", imm, 0);
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_retired", retired, 0);

    // Streaming with ready held high and zero-wait memory.
    mem[0] = 8'd5; mem[1] = 8'd7; mem[2] = 8'd13; mem[3] = 8'h3C; mem[4] = 8'd9;
    exp_q.push_back({8'd5, 8'd0});
    exp_q.push_back({8'd7, 8'd0});
    exp_q.push_back({8'd13, 8'h3C});
    for (int a = 0; a < 5; a++) exp_addr_q.push_back(8'(a));
    instr_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    check_eq("t1_req", imem_req, 1);
    check_eq("t1_addr", imem_addr, 0);
    check_eq("t1_valid0", instr_valid, 0);
    tick();
    check_eq("t1_valid1", instr_valid, 1);
    check_eq("t1_pc", pc, 1);
    check_eq("t1_req_drop", imem_req, 0);
    check_eq("t1_retired0", retired, 0);
    tick();
    check_eq("t1_retired1", retired, 1);
    check_eq("t1_nop", instr, 12);
    check_eq("t1_addr1", imem_addr, 1);
    cycles = 3;
    while (retired != 16'd3 && cycles < 20) begin
      tick();
      cycles++;
    end
    check_eq("t1_cycles", cycles, 8);
    instr_ready = 1'b0;
    tick();
    check_eq("t1_hold_instr", instr, 9);
    check_eq("t1_hold_pc", pc, 5);
    check_eq("t1_sb_drain", exp_q.size(), 0);

    // LDI from reset: valid rises on the third edge.
    hard_reset();
    mem[0] = 8'd13; mem[1] = 8'hA5;
    exp_addr_q.push_back(8'h00);
    exp_addr_q.push_back(8'h01);
    exp_q.push_back({8'd13, 8'hA5});
    rst_n = 1'b1;
    cycles = 0;
    while (!instr_valid && cycles < 10) begin
      tick();
      cycles++;
    end
    check_eq("t2_latency", cycles, 3);
    check_eq("t2_instr", instr, 13);
    check_eq("t2_imm", imm, 8'hA5);
    check_eq("t2_pc", pc, 2);
    accept(1'b0, 8'h00, 1'b0);
    check_eq("t2_retired", retired, 1);
    check_eq("t2_sb_drain", exp_q.size(), 0);

    // Jump on accept; jump/soft reset without ready is ignored.
    hard_reset();
    mem[4] = 8'd14; mem[8'h40] = 8'h22; mem[8'h41] = 8'h33;
    for (int a = 0; a < 5; a++) exp_addr_q.push_back(8'(a));
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({8'd1, 8'd0});
      wait_valid("t3_seq", 6);
      accept(1'b0, 8'h00, 1'b0);
    end
    exp_q.push_back({8'd14, 8'd0});
    wait_valid("t3_jmp", 6);
    jmp_en = 1'b1; jmp_target = 8'h77; soft_rst = 1'b1;
    tick();
    jmp_en = 1'b0; soft_rst = 1'b0;
    check_eq("t3_hold_valid", instr_valid, 1);
    check_eq("t3_hold_instr", instr, 14);
    check_eq("t3_hold_pc", pc, 5);
    check_eq("t3_hold_retired", retired, 4);
    exp_addr_q.push_back(8'h40);
    accept(1'b1, 8'h40, 1'b0);
    check_eq("t3_jmp_pc", pc, 8'h40);
    check_eq("t3_jmp_addr", imem_addr, 8'h40);
    check_eq("t3_jmp_req", imem_req, 1);

    // Soft reset wins over a simultaneous jump.
    exp_q.push_back({8'h22, 8'd0});
    wait_valid("t4_a", 6);
    exp_addr_q.push_back(8'h41);
    accept(1'b0, 8'h00, 1'b0);
    exp_q.push_back({8'h33, 8'd0});
    wait_valid("t4_b", 6);
    exp_addr_q.push_back(8'h00);
    accept(1'b1, 8'h80, 1'b1);
    check_eq("t4_pc", pc, 0);
    check_eq("t4_addr", imem_addr, 0);
    check_eq("t4_retired", retired, 7);
    check_eq("t4_sb_drain", exp_q.size(), 0);

    // LDI at 0xFF with 3 wait states: immediate comes from address 0.
    hard_reset();
    mem[0] = 8'h5A; mem[8'hFF] = 8'd13;
    exp_addr_q.push_back(8'h00);
    exp_q.push_back({8'h5A, 8'd0});
    rst_n = 1'b1;
    wait_valid("t5_first", 6);
    ack_wait = 3;
    exp_addr_q.push_back(8'hFF);
    exp_addr_q.push_back(8'h00);
    accept(1'b1, 8'hFF, 1'b0);
    check_eq("t5_addr", imem_addr, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("t5_stable_addr", imem_addr, 8'hFF);
      check_eq("t5_stable_req", imem_req, 1);
      check_eq("t5_stable_valid", instr_valid, 0);
    end
    tick();
    check_eq("t5_imm_addr", imem_addr, 8'h00);
    check_eq("t5_wrap_pc", pc, 0);
    check_eq("t5_imm_req", imem_req, 1);
    wait_valid("t5_ldi", 8);
    check_eq("t5_instr", instr, 13);
    check_eq("t5_imm", imm, 8'h5A);
    check_eq("t5_pc", pc, 1);
    check_eq("t5_sb_drain", exp_q.size(), 0);

    // Async reset while issuing with ready low, then a stale ack after release.
    check_eq("t6_pre_retired", retired, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_valid", instr_valid, 0);
    check_eq("t6_instr", instr, 12);
    check_eq("t6_imm", imm, 0);
    check_eq("t6_retired", retired, 0);
    check_eq("t6_req", imem_req, 0);
    check_eq("t6_pc", pc, 0);
    tick();
    ack_wait = 0;
    exp_q.delete();
    exp_addr_q.delete();
    mem[0] = 8'h21;
    exp_addr_q.push_back(8'h00);
    exp_q.push_back({8'h21, 8'd0});
    stray_ack = 1'b1;
    rst_n = 1'b1;
    tick();
    stray_ack = 1'b0;
    check_eq("t6_restart_req", imem_req, 1);
    check_eq("t6_restart_addr", imem_addr, 0);
    check_eq("t6_restart_pc", pc, 0);
    check_eq("t6_restart_valid", instr_valid, 0);
    wait_valid("t6_fetch", 6);
    accept(1'b0, 8'h00, 1'b0);
    check_eq("t6_retired1", retired, 1);
    check_eq("t6_sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
